sfx_sequencer: RTL and testbench

Sound-effect arbiter and sequencer for the single audio output. Accepts one-cycle event pulses from the game logic (wall bounce, paddle hit, brick hit, ball lost), latches them and grants the tone generator to one effect at a time by fixed priority. Plays each granted effect as a square wave for a fixed duration, then holds a short silent gap. Sits between `GameLogic` and the `AUDIO_OUT` pin, replacing the free-running `AudioPlayer` drive.

---
 rtl/breakout_pkg.sv | 26 ++
 rtl/ms_ticker.sv | 31 +++
 rtl/sfx_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sfx_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout sound path: effect ids, sequencer states,
// default millisecond prescale and the fixed-priority pick of a pending effect.
package breakout_pkg;

  localparam logic [1:0] SFX_WALL   = 2'd0;
  localparam logic [1:0] SFX_PADDLE = 2'd1;
  localparam logic [1:0] SFX_BRICK  = 2'd2;
  localparam logic [1:0] SFX_LOST   = 2'd3;

  localparam int TICKS_PER_MS = 40000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } sfx_state_e;

  // Effect ids are numbered so that a larger id means a higher priority.
  function automatic logic [1:0] sfx_highest(input logic [3:0] pend);
    if (pend[3])      return SFX_LOST;
    else if (pend[2]) return SFX_BRICK;
    else if (pend[1]) return SFX_PADDLE;
    else              return SFX_WALL;
  endfunction

endpackage

// File: rtl/ms_ticker.sv
// Millisecond prescaler: down-counter with synchronous restart; tick is high
// for the one cycle in which the count sits at zero.
module ms_ticker
  import breakout_pkg::*;
#(
  parameter int TICK_DIV = TICKS_PER_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(TICK_DIV - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || (count == 16'd0)) begin
      count <= RELOAD;
    end else begin
      count <= count - 16'd1;
    end
  end

  // Not gated by restart: the sequencer decides its GAP entry from tick.
  assign tick = (count == 16'd0);

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect arbiter and sequencer: latches event pulses, grants the tone
// generator by fixed priority, plays a square wave for the effect duration, then a gap.
//
// state   | meaning
// IDLE    | silent, waiting for a pending effect
// PLAY    | tone running for the granted effect; higher-priority pending preempts
// GAP     | silent spacer of GAP_MS between effects
module sfx_sequencer
  import breakout_pkg::*;
#(
  parameter int TICK_DIV   = TICKS_PER_MS,
  parameter int GAP_MS     = 20,
  parameter int HP_WALL    = 40000,
  parameter int HP_PADDLE  = 20000,
  parameter int HP_BRICK   = 10000,
  parameter int HP_LOST    = 30000,
  parameter int DUR_WALL   = 30,
  parameter int DUR_PADDLE = 40,
  parameter int DUR_BRICK  = 50,
  parameter int DUR_LOST   = 250
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       EVT_WALL,
  input  logic       EVT_PADDLE,
  input  logic       EVT_BRICK,
  input  logic       EVT_LOST,
  input  logic       MUTE,
  output logic       AUDIO_OUT,
  output logic       BUSY,
  output logic [1:0] ACTIVE_SFX
);

  localparam logic [16:0] HP_W      = 17'(HP_WALL);
  localparam logic [16:0] HP_P      = 17'(HP_PADDLE);
  localparam logic [16:0] HP_B      = 17'(HP_BRICK);
  localparam logic [16:0] HP_L      = 17'(HP_LOST);
  localparam logic [16:0] HP_L2     = 17'(2 * HP_LOST);
  localparam logic [7:0]  DUR_W     = 8'(DUR_WALL);
  localparam logic [7:0]  DUR_P     = 8'(DUR_PADDLE);
  localparam logic [7:0]  DUR_B     = 8'(DUR_BRICK);
  localparam logic [7:0]  DUR_L     = 8'(DUR_LOST);
  localparam logic [7:0]  LOST_HALF = 8'(DUR_LOST / 2);
  localparam logic [7:0]  GAP_LD    = 8'(GAP_MS);

  sfx_state_e  state, state_nxt;
  logic [3:0]  pending, pending_nxt, evt, grant_mask;
  logic [1:0]  cur_sfx, hi_id;
  logic [7:0]  ms_cnt, ms_after;
  logic [16:0] tone_cnt, hp_cur;
  logic        tone_bit, grant, enter_gap, tick, restart, ms_last;

  function automatic logic [16:0] hp_of(input logic [1:0] id);
    case (id)
      SFX_WALL:   return HP_W;
      SFX_PADDLE: return HP_P;
      SFX_BRICK:  return HP_B;
      default:    return HP_L;
    endcase
  endfunction

  function automatic logic [7:0] dur_of(input logic [1:0] id);
    case (id)
      SFX_WALL:   return DUR_W;
      SFX_PADDLE: return DUR_P;
      SFX_BRICK:  return DUR_B;
      default:    return DUR_L;
    endcase
  endfunction

  ms_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .restart (restart),
    .tick    (tick)
  );

  assign evt     = {EVT_LOST, EVT_BRICK, EVT_PADDLE, EVT_WALL};
  assign hi_id   = sfx_highest(pending);
  assign ms_last = tick && (ms_cnt == 8'd1);
  assign restart = grant || enter_gap;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    enter_gap = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          grant     = 1'b1;
          state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Preemption wins over the natural end of the effect in the same cycle.
        if ((|pending) && (hi_id > cur_sfx)) begin
          grant = 1'b1;
        end else if (ms_last) begin
          enter_gap = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (ms_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign grant_mask  = grant ? (4'b0001 << hi_id) : 4'b0000;
  assign pending_nxt = (pending & ~grant_mask) | evt;

  // Remaining ms as it will read next cycle, so the LOST pitch drop lands on a tick boundary.
  assign ms_after = (tick && (ms_cnt != 8'd0)) ? (ms_cnt - 8'd1) : ms_cnt;

  always_comb begin
    hp_cur = hp_of(cur_sfx);
    if ((cur_sfx == SFX_LOST) && (ms_after <= LOST_HALF)) hp_cur = HP_L2;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending   <= '0;
      cur_sfx   <= SFX_WALL;
      ms_cnt    <= '0;
      tone_cnt  <= '0;
      tone_bit  <= 1'b0;
      AUDIO_OUT <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      AUDIO_OUT <= tone_bit & ~MUTE;
      if (grant) begin
        cur_sfx  <= hi_id;
        ms_cnt   <= dur_of(hi_id);
        tone_cnt <= hp_of(hi_id) - 17'd1;
        tone_bit <= 1'b1;
      end else if (enter_gap) begin
        ms_cnt   <= GAP_LD;
        tone_cnt <= '0;
        tone_bit <= 1'b0;
      end else begin
        if (tick && (ms_cnt != 8'd0)) ms_cnt <= ms_cnt - 8'd1;
        if (state == ST_PLAY) begin
          if (tone_cnt == 17'd0) begin
            tone_bit <= ~tone_bit;
            tone_cnt <= hp_cur - 17'd1;
          end else begin
            tone_cnt <= tone_cnt - 17'd1;
          end
        end else begin
          tone_cnt <= '0;
          tone_bit <= 1'b0;
        end
      end
    end
  end

  assign BUSY       = (state != ST_IDLE);
  assign ACTIVE_SFX = (state == ST_PLAY) ? cur_sfx : SFX_WALL;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: a per-cycle behavioural model predicts
// BUSY/ACTIVE_SFX/AUDIO_OUT, a monitor pops and compares after every clock edge.
module tb_sfx_sequencer;

  localparam int TD  = 10;
  localparam int GAP = 2;
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_GAP = 2;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       EVT_WALL = 1'b0, EVT_PADDLE = 1'b0, EVT_BRICK = 1'b0, EVT_LOST = 1'b0;
  logic       MUTE = 1'b0;
  logic       AUDIO_OUT, BUSY;
  logic [1:0] ACTIVE_SFX;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  int aud_cnt = 0;

  logic [3:0] exp_q[$];

  // reference model state
  int       m_phase = PH_IDLE;
  int       m_cur = 0;
  int       m_el = 0;
  bit [3:0] m_pend = '0;
  bit       m_tone = 1'b0;
  bit       m_audio = 1'b0;

  always #5 CLK = ~CLK;

  sfx_sequencer #(
    .TICK_DIV(TD), .GAP_MS(GAP),
    .HP_WALL(4), .HP_PADDLE(3), .HP_BRICK(2), .HP_LOST(5),
    .DUR_WALL(3), .DUR_PADDLE(3), .DUR_BRICK(3), .DUR_LOST(6)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .EVT_WALL(EVT_WALL), .EVT_PADDLE(EVT_PADDLE), .EVT_BRICK(EVT_BRICK), .EVT_LOST(EVT_LOST),
    .MUTE(MUTE), .AUDIO_OUT(AUDIO_OUT), .BUSY(BUSY), .ACTIVE_SFX(ACTIVE_SFX)
  );

  function automatic int hp_of(int id);
    case (id)
      0: return 4;
      1: return 3;
      2: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int dur_of(int id);
    return (id == 3) ? 6 : 3;
  endfunction

  function automatic int highest(bit [3:0] p);
    for (int i = 3; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  // Tone level k cycles into an effect: walk half-periods from a high start;
  // LOST half-periods starting at or below half the remaining ms are doubled.
  function automatic bit tone_at(int id, int k);
    int t = 0;
    bit lvl = 1'b1;
    int hp;
    for (int guard = 0; guard < 10000; guard++) begin
      hp = hp_of(id);
      if (id == 3 && (dur_of(3) - t / TD) <= dur_of(3) / 2) hp = 2 * hp;
      if (k < t + hp) return lvl;
      t += hp;
      lvl = ~lvl;
    end
    return 1'b0;
  endfunction

  task automatic grant_to(int id);
    m_cur = id;
    m_pend[id] = 1'b0;
    m_phase = PH_PLAY;
    m_el = 0;
  endtask

  // Drive one cycle of inputs and push the outputs expected after the next rising edge.
  task automatic step(input bit [3:0] evt, input bit mute, input bit rst_n);
    bit new_audio;
    int h;
    @(negedge CLK);
    RESET_N = rst_n;
    {EVT_LOST, EVT_BRICK, EVT_PADDLE, EVT_WALL} = evt;
    MUTE = mute;
    if (!rst_n) begin
      m_phase = PH_IDLE; m_cur = 0; m_el = 0; m_pend = '0; m_tone = 1'b0; m_audio = 1'b0;
    end else begin
      new_audio = m_tone & ~mute;
      h = highest(m_pend);
      case (m_phase)
        PH_IDLE: if (h >= 0) grant_to(h);
        PH_PLAY: begin
          if (h > m_cur) grant_to(h);
          else begin
            m_el++;
            if (m_el == dur_of(m_cur) * TD) begin m_phase = PH_GAP; m_el = 0; end
          end
        end
        default: begin
          m_el++;
          if (m_el == GAP * TD) m_phase = PH_IDLE;
        end
      endcase
      m_pend |= evt;
      m_tone = (m_phase == PH_PLAY) ? tone_at(m_cur, m_el) : 1'b0;
      m_audio = new_audio;
    end
    exp_q.push_back({(m_phase != PH_IDLE), (m_phase == PH_PLAY) ? 2'(m_cur) : 2'd0, m_audio});
  endtask

  task automatic idle(int n, bit mute = 1'b0);
    for (int i = 0; i < n; i++) step(4'b0000, mute, 1'b1);
  endtask

  task automatic check_count(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // monitor: compare every presented output against the popped expectation
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (BUSY === 1'b1) busy_cnt++;
      if (AUDIO_OUT === 1'b1) aud_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (BUSY !== e[3]) begin
          errors++;
          $display("FAIL busy @%0t: got %b want %b", $time, BUSY, e[3]);
        end
        if (ACTIVE_SFX !== e[2:1]) begin
          errors++;
          $display("FAIL active_sfx @%0t: got %0d want %0d", $time, ACTIVE_SFX, e[2:1]);
        end
        if (AUDIO_OUT !== e[0]) begin
          errors++;
          $display("FAIL audio_out @%0t: got %b want %b", $time, AUDIO_OUT, e[0]);
        end
      end
    end
  end

  initial begin
    int b0, a0;
    bit m;
    // reset held while brick pulses; released with no event present
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
    idle(20);

    // lone paddle: 30 cycles of tone with period 6, then 20-cycle gap
    b0 = busy_cnt; a0 = aud_cnt;
    step(4'b0010, 1'b0, 1'b1);
    idle(70);
    check_count("paddle_busy_cycles", busy_cnt - b0, 50);
    check_count("paddle_audio_high_cycles", aud_cnt - a0, 15);

    // wall and lost together: lost first, then wall after the gap
    step(4'b1001, 1'b0, 1'b1);
    idle(150);

    // brick preempts wall 10 cycles in; wall not replayed
    step(4'b0001, 1'b0, 1'b1);
    idle(10);
    step(4'b0100, 1'b0, 1'b1);
    idle(60);

    // wall during brick waits for brick's gap
    step(4'b0100, 1'b0, 1'b1);
    idle(5);
    step(4'b0001, 1'b0, 1'b1);
    idle(110);

    // muted paddle: same sequencing, silent output
    b0 = busy_cnt; a0 = aud_cnt;
    step(4'b0010, 1'b1, 1'b1);
    idle(70, 1'b1);
    check_count("muted_busy_cycles", busy_cnt - b0, 50);
    check_count("muted_audio_high_cycles", aud_cnt - a0, 0);

    // reset mid-effect discards everything
    step(4'b1000, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b1);
    idle(15);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(30);

    // randomized traffic
    m = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      bit [3:0] ev;
      for (int b = 0; b < 4; b++) ev[b] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) m = ~m;
      if ($urandom_range(0, 699) == 0) begin
        step(ev, m, 1'b0);
        step(4'b0000, m, 1'b0);
      end else begin
        step(ev, m, 1'b1);
      end
    end
    idle(3);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
